// File: rtl/sercmp_x1.sv
`default_nettype none
// ============================================================================
//  Module      : sercmp_x1
//  Description : Bit-serial equality checker. Accumulates XNOR(i0,i1) over a
//                frame of WIDTH enabled bits and reports the frame result
//                (all-equal flag and mismatch count) with a one-cycle valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module sercmp_x1 #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          i0,
    input  logic          i1,
    input  logic          en,
    input  logic          start,
    output logic          q,
    output logic          valid,
    output logic          busy,
    output logic [CW-1:0] mmcnt
);

    // Bit counter only needs to reach WIDTH-1; the frame closes on that bit.
    localparam int                c_CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNTW-1:0] c_LAST = c_CNTW'(WIDTH - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;

    logic [c_CNTW-1:0] r_cnt;
    logic              r_eq;
    logic [CW-1:0]     r_mm;

    logic              r_q;
    logic              r_valid;
    logic [CW-1:0]     r_mmcnt;

    logic              w_run;
    logic              w_mis;
    logic              w_old_last;
    logic              w_restart;
    logic              w_sample;
    logic              w_done;
    logic [c_CNTW-1:0] w_base_cnt;
    logic              w_base_eq;
    logic [CW-1:0]     w_base_mm;
    logic [c_CNTW-1:0] w_cnt_nxt;
    logic              w_eq_nxt;
    logic [CW-1:0]     w_mm_nxt;

    assign w_run      = (r_state == c_RUN);
    assign w_mis      = i0 ^ i1;

    // An enabled bit at count WIDTH-1 in RUN closes the current frame; a start
    // on that same edge does not abort it but arms the following frame.
    assign w_old_last = w_run && en && (r_cnt == c_LAST);
    assign w_restart  = start && !w_old_last;

    // On a (re)start the accumulation begins from a clean slate, and the bit
    // sampled in that cycle (if any) is bit 0 of the new frame.
    assign w_base_cnt = w_restart ? '0   : r_cnt;
    assign w_base_eq  = w_restart ? 1'b1 : r_eq;
    assign w_base_mm  = w_restart ? '0   : r_mm;

    assign w_sample   = en && (w_run || w_restart);
    assign w_done     = w_sample && (w_base_cnt == c_LAST);

    assign w_cnt_nxt  = w_sample ? (w_base_cnt + c_CNTW'(1))  : w_base_cnt;
    assign w_eq_nxt   = w_sample ? (w_base_eq & ~w_mis)       : w_base_eq;
    assign w_mm_nxt   = w_sample ? (w_base_mm + CW'(w_mis))   : w_base_mm;

    // State register
    always_ff @(posedge ck) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: completion wins, then (re)start, else hold
    always_comb begin
        w_state_nxt = r_state;
        if (w_done) begin
            w_state_nxt = (w_old_last && start) ? c_RUN : c_IDLE;
        end else if (w_restart) begin
            w_state_nxt = c_RUN;
        end
    end

    // Output logic: busy mirrors the RUN state
    always_comb begin
        busy = (r_state == c_RUN);
    end

    // Running accumulation; cleared whenever a frame completes
    always_ff @(posedge ck) begin
        if (rst || w_done) begin
            r_cnt <= '0;
            r_eq  <= 1'b1;
            r_mm  <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_eq  <= w_eq_nxt;
            r_mm  <= w_mm_nxt;
        end
    end

    // Frame result registers; q/mmcnt hold until the next completed frame
    always_ff @(posedge ck) begin
        if (rst) begin
            r_q     <= 1'b0;
            r_valid <= 1'b0;
            r_mmcnt <= '0;
        end else begin
            r_valid <= w_done;
            if (w_done) begin
                r_q     <= w_eq_nxt;
                r_mmcnt <= w_mm_nxt;
            end
        end
    end

    assign q     = r_q;
    assign valid = r_valid;
    assign mmcnt = r_mmcnt;

endmodule
`default_nettype wire

// File: tb/tb_sercmp_x1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sercmp_x1
//  Description : Self-checking bench for sercmp_x1 with a frame-level model
//                (queue of sampled mismatch bits per frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sercmp_x1;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic          ck = 1'b0;
    logic          rst = 1'b1;
    logic          i0 = 1'b0;
    logic          i1 = 1'b0;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic          q;
    logic          valid;
    logic          busy;
    logic [CW-1:0] mmcnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit            m_inframe = 1'b0;
    int            m_bits[$];
    bit            m_q = 1'b0;
    bit            m_valid = 1'b0;
    int            m_mm = 0;

    sercmp_x1 #(.WIDTH(WIDTH), .CW(CW)) dut (
        .ck    (ck),
        .rst   (rst),
        .i0    (i0),
        .i1    (i1),
        .en    (en),
        .start (start),
        .q     (q),
        .valid (valid),
        .busy  (busy),
        .mmcnt (mmcnt)
    );

    always #5 ck = ~ck;

    // Close the model frame: result is derived from the collected mismatch bits
    task automatic model_complete();
        int s;
        s = m_bits.sum();
        m_q     = (s == 0);
        m_mm    = s;
        m_valid = 1'b1;
        m_bits.delete();
    endtask

    // Frame-level behaviour for one clock edge
    task automatic model_edge(input bit r, input bit s, input bit e, input bit a, input bit b);
        if (r) begin
            m_inframe = 1'b0;
            m_bits.delete();
            m_q = 1'b0; m_mm = 0; m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_inframe && e && m_bits.size() == WIDTH - 1) begin
                m_bits.push_back(int'(a != b));
                model_complete();
                m_inframe = s;
            end else if (s) begin
                m_bits.delete();
                m_inframe = 1'b1;
                if (e) m_bits.push_back(int'(a != b));
                if (m_bits.size() == WIDTH) begin
                    model_complete();
                    m_inframe = 1'b0;
                end
            end else if (m_inframe && e) begin
                m_bits.push_back(int'(a != b));
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, update model, settle past the edge
    task automatic step(input bit r, input bit s, input bit e, input bit a, input bit b);
        @(negedge ck);
        rst = r; start = s; en = e; i0 = a; i1 = b;
        @(posedge ck);
        model_edge(r, s, e, a, b);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            n_checks++; if (q !== 1'b0) begin n_fail++; $display("FAIL reset_q: got %b want 0", q); end
            n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
            n_checks++; if (mmcnt !== '0) begin n_fail++; $display("FAIL reset_mmcnt: got %0d want 0", mmcnt); end
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            n_checks++;
            if ({q, valid, busy, mmcnt} !== '0) begin
                n_fail++; $display("FAIL post_reset_idle: q=%b valid=%b busy=%b mmcnt=%0d want all 0", q, valid, busy, mmcnt);
            end
        end
    endtask

    task automatic test_match();
        logic [7:0] pat;
        pat = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, k == 0, 1'b1, pat[7-k], pat[7-k]);
            if (k < 7) begin
                n_checks++;
                if (valid !== 1'b0 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL match_inflight bit%0d: valid=%b busy=%b want 0/1", k, valid, busy);
                end
            end
        end
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL match_valid: got %b want 1", valid); end
        n_checks++; if (q !== 1'b1) begin n_fail++; $display("FAIL match_q: got %b want 1", q); end
        n_checks++; if (mmcnt !== 4'd0) begin n_fail++; $display("FAIL match_mmcnt: got %0d want 0", mmcnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL match_busy: got %b want 0", busy); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (valid !== 1'b0 || q !== 1'b1) begin n_fail++; $display("FAIL match_hold: valid=%b q=%b want 0/1", valid, q); end
    endtask

    task automatic test_gaps();
        logic [7:0] a, b;
        int bitn;
        a = 8'hA5; b = 8'h24; bitn = 0;
        for (int k = 0; k < 15; k++) begin
            if (k % 2 == 0) begin
                step(1'b0, k == 0, 1'b1, a[7-bitn], b[7-bitn]);
                bitn++;
            end else begin
                step(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
                n_checks++;
                if (valid !== 1'b0 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL gaps_hold cyc%0d: valid=%b busy=%b want 0/1", k, valid, busy);
                end
            end
        end
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL gaps_valid: got %b want 1", valid); end
        n_checks++; if (q !== 1'b0) begin n_fail++; $display("FAIL gaps_q: got %b want 0", q); end
        n_checks++; if (mmcnt !== 4'd2) begin n_fail++; $display("FAIL gaps_mmcnt: got %0d want 2", mmcnt); end
        n_checks++; if (mmcnt !== CW'(m_mm)) begin n_fail++; $display("FAIL gaps_model: got %0d want %0d", mmcnt, m_mm); end
    endtask

    task automatic test_abort();
        bit saw_valid;
        bit v;
        saw_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, k == 0, 1'b1, 1'b1, 1'b0);
            saw_valid |= valid;
        end
        for (int k = 0; k < 8; k++) begin
            v = 1'($urandom);
            step(1'b0, k == 0, 1'b1, v, v);
            if (k < 7) saw_valid |= valid;
        end
        n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL abort_novalid: got valid 1 want none"); end
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL abort_valid: got %b want 1", valid); end
        n_checks++; if (q !== 1'b1 || mmcnt !== 4'd0) begin n_fail++; $display("FAIL abort_result: q=%b mmcnt=%0d want 1/0", q, mmcnt); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) step(1'b0, (k == 0) || (k == 7), 1'b1, 1'b0, 1'b0);
        n_checks++; if (valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_first: valid=%b busy=%b want 1/1", valid, busy); end
        n_checks++; if (q !== 1'b1 || mmcnt !== 4'd0) begin n_fail++; $display("FAIL b2b_first_result: q=%b mmcnt=%0d want 1/0", q, mmcnt); end
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_second: valid=%b busy=%b want 1/0", valid, busy); end
        n_checks++; if (q !== 1'b0 || mmcnt !== 4'd8) begin n_fail++; $display("FAIL b2b_second_result: q=%b mmcnt=%0d want 0/8", q, mmcnt); end
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 4; k++) step(1'b0, k == 0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({q, valid, busy, mmcnt} !== '0) begin
            n_fail++; $display("FAIL midrst: q=%b valid=%b busy=%b mmcnt=%0d want all 0", q, valid, busy, mmcnt);
        end
        for (int k = 0; k < 8; k++) step(1'b0, k == 0, 1'b1, 1'($urandom), 1'($urandom));
        n_checks++;
        if (valid !== 1'b1 || q !== m_q || mmcnt !== CW'(m_mm)) begin
            n_fail++; $display("FAIL midrst_next: valid=%b q=%b mmcnt=%0d want 1/%b/%0d", valid, q, mmcnt, m_q, m_mm);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) == 0) ? 1'($urandom) : i0);
            n_checks++;
            if (valid !== m_valid || q !== m_q || busy !== m_inframe || mmcnt !== CW'(m_mm)) begin
                n_fail++;
                if (errs < 10) $display("FAIL random cyc%0d: q=%b valid=%b busy=%b mmcnt=%0d want %b/%b/%b/%0d",
                                        k, q, valid, busy, mmcnt, m_q, m_valid, m_inframe, m_mm);
                errs++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_gaps();
        test_abort();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sercmp_x1.md
Name: sercmp_x1

Overview:
- Bit-serial equality checker; consumes two serial bitstreams one bit per enabled clock.
- Per bit it forms the XNOR of i0 and i1, and accumulates the result over a frame of WIDTH bits.
- At the end of each frame it reports whether the frame matched and how many bits mismatched.
- Sits directly downstream of the 2-input XNOR cell function: it is the sequential accumulator for serial compare and self-test paths in the mcu9t3v3 library flavour.

Parameters:
- WIDTH, 8, number of enabled bits per frame; legal range 1..255.
- CW, 4, width of the mismatch counter; must satisfy 2**CW > WIDTH.

Ports:
- ck  input  1  clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- i0  input  1  serial data stream A.
- i1  input  1  serial data stream B.
- en  input  1  bit-valid strobe; i0/i1 are sampled only when en=1.
- start  input  1  frame sync; arms a new frame.
- q  output  1  frame result; 1 = all WIDTH bit pairs were equal.
- valid  output  1  one-cycle pulse marking new q/mmcnt.
- busy  output  1  1 while a frame is in progress.
- mmcnt  output  CW  number of mismatched bit pairs in the last completed frame.

Behaviour:
- Interface: one clock, ck; rst is synchronous and active-high.
- All state updates on the rising edge of ck.
- Reset (rst=1 at an edge): state=IDLE, q=0, valid=0, busy=0, mmcnt=0; bit counter=0; running eq flag=1; running mismatch count=0.
- rst has priority over every other input, including reset asserted mid-frame: the frame is discarded and no valid is issued.
- States: IDLE, RUN.
- IDLE:
  - start=1 → RUN; counter, running eq and running count are cleared.
  - If en=1 in the same cycle, that bit is bit 0 of the frame.
  - start=0 → stay in IDLE; en is ignored.
- RUN:
  - Each edge with en=1 samples one bit: eq &= ~(i0^i1); running count increments when i0!=i1; counter increments.
  - Edges with en=0 hold all state.
- Frame end: on the edge that samples the WIDTH-th enabled bit:
  - q <= final eq (including that bit); mmcnt <= final count (including that bit).
  - valid <= 1 for exactly one cycle; state → IDLE; busy <= 0.
  - Result visible the cycle after the last bit edge (latency 1 edge).
- start=1 while in RUN, not on the last bit: aborts the current frame with no valid, clears the running state, and restarts.
  - If en=1 in that cycle, the bit is bit 0 of the new frame.
- start=1 on the last-bit edge: the current frame completes normally (valid pulses with its result) and the state goes directly to RUN for a new frame.
  - That en bit belongs to the old frame; the new frame's bit 0 is the next enabled bit.
- WIDTH=1: a start+en edge completes a frame immediately and returns to IDLE; valid pulses next cycle.
- q and mmcnt hold their last values until the next frame completes or reset. valid is never high for two consecutive cycles unless back-to-back frames complete on consecutive edges (only possible for WIDTH=1).
- busy=1 exactly while state=RUN.
- mmcnt never wraps because 2**CW > WIDTH.

Test Plan:
- Reset: drive rst=1 for 2 edges with random i0/i1/en/start → q=0, valid=0, busy=0, mmcnt=0. Release rst with start=0 → outputs stay 0.
- Match frame (WIDTH=8): start+en with i0=i1 on 8 consecutive enabled edges, pattern 0xA5 → valid one cycle after the 8th edge, q=1, mmcnt=0, busy low the same cycle.
- Mismatch with gaps (WIDTH=8): i0=0xA5, i1=0x24, en toggling 1,0,1… → after 8 enabled bits, q=0, mmcnt=2. No sampling occurs on en=0 cycles.
- Abort: start a frame, feed 5 mismatching bits, pulse start+en → no valid for the first frame. A subsequent 8-bit matching frame (counting the restart bit) gives q=1, mmcnt=0.
- Back-to-back: start asserted on the 8th-bit edge → valid pulse with frame-1 result; busy stays 1. A second frame of all mismatches gives q=0, mmcnt=8.
- Reset mid-frame: rst at bit 4 → no valid; q and mmcnt return to 0. A new frame after reset completes normally.
